// File: rtl/timer_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter serialising CPU-bus (port 0) and debug-host (port 1) accesses
// onto the single RRIOT interval-timer register interface.
module timer_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0_n,
    input  logic       we1_n,
    input  logic [2:0] a0,
    input  logic [2:0] a1,
    input  logic [7:0] wd0,
    input  logic [7:0] wd1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rd0,
    output logic [7:0] rd1,
    output logic       t_enable,
    output logic       t_we_n,
    output logic [2:0] t_A,
    output logic [7:0] t_DI,
    input  logic [7:0] t_DO,
    output logic       busy,
    output logic       gnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t state;
    logic   last_gnt;
    logic   acc_rd;
    logic   win;

    // Under contention round-robin favours whoever was not served last.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1)
            return PRIO_FIXED ? 1'b0 : ~last;
        else
            return r1 && !r0;
    endfunction

    always_comb begin
        win = pick_winner(req0, req1, last_gnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            acc_rd   <= 1'b0;
            gnt      <= 1'b0;
            busy     <= 1'b0;
            t_enable <= 1'b0;
            t_we_n   <= 1'b1;
            t_A      <= 3'd0;
            t_DI     <= 8'd0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rd0      <= 8'd0;
            rd1      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= win;
                        acc_rd   <= win ? we1_n : we0_n;
                        t_we_n   <= win ? we1_n : we0_n;
                        t_A      <= win ? a1 : a0;
                        t_DI     <= win ? wd1 : wd0;
                        t_enable <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    t_enable <= 1'b0;
                    t_we_n   <= 1'b1;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    // The timer registers its read data one cycle after the enable strobe.
                    if (acc_rd) begin
                        if (gnt)
                            rd1 <= t_DO;
                        else
                            rd0 <= t_DO;
                    end
                    if (gnt)
                        ack1 <= 1'b1;
                    else
                        ack0 <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    last_gnt <= gnt;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
